// File: rtl/bus_dma_master.sv
// ---------------------------------------------------------------------------
// bus_dma_master
//
// Purpose:
//   A second initiator on the CPU memory bus. It copies a block of words from
//   one address range to another without CPU involvement. Bus ownership comes
//   from an external arbiter through bus_req/bus_gnt. The top level muxes this
//   block's mem_addr/mem_cmd/out onto the bus while bus_gnt is high.
//   Each word is a three-cycle sequence: RD0 and RD1 present the read address,
//   and WR writes the captured word. Addresses wrap modulo 2**AW.
//
// Optional feature (compile-time macro DMA_FILL_EN):
//   When DMA_FILL_EN is defined, the fill input is latched at start. In fill
//   mode the read phase is skipped. The destination range is written with
//   src_addr zero-extended to DW bits, at one word per cycle.
//   When DMA_FILL_EN is not defined, fill is ignored and every transfer is a copy.
//
// Ports:
//   clk       in   1      system clock, all state changes on posedge
//   reset_n   in   1      asynchronous active-low reset
//   start     in   1      one-cycle pulse; latches src/dst/len; honoured in IDLE only
//   src_addr  in   AW     first source word address (fill word in fill mode)
//   dst_addr  in   AW     first destination word address
//   len       in   LEN_W  number of words to move (0 = complete immediately)
//   fill      in   1      fill mode select (only with DMA_FILL_EN)
//   bus_gnt   in   1      arbiter grant, high = this block owns the bus
//   in        in   DW     bus read data, valid one cycle after MREAD address
//   bus_req   out  1      bus ownership request
//   mem_addr  out  AW     bus address
//   mem_cmd   out  2      00 none, 01 MREAD, 10 MWRITE
//   out       out  DW     bus write data
//   busy      out  1      transfer in progress
//   done      out  1      one-cycle pulse at completion
// ---------------------------------------------------------------------------
module bus_dma_master #(
    parameter int AW    = 9,
    parameter int DW    = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [AW-1:0]    src_addr,
    input  logic [AW-1:0]    dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             fill,
    input  logic             bus_gnt,
    input  logic [DW-1:0]    in,
    output logic             bus_req,
    output logic [AW-1:0]    mem_addr,
    output logic [1:0]       mem_cmd,
    output logic [DW-1:0]    out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD0,
        RD1,
        WR,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [AW-1:0]    sa;
    logic [AW-1:0]    da;
    logic [LEN_W-1:0] cnt;
    logic [DW-1:0]    data_reg;
    logic             fill_mode;
    logic             last_word;

    // cnt still holds the count of words left, including the one in WR.
    assign last_word = (cnt == LEN_W'(1));

`ifdef DMA_FILL_EN
    logic [DW-1:0] fill_word;

    assign fill_word = {{(DW-AW){1'b0}}, src_addr};

    // The fill mode is latched together with the other transfer parameters.
    // A start while busy therefore cannot change it mid-transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_mode <= 1'b0;
        end else if (state == IDLE && start) begin
            fill_mode <= fill;
        end
    end
`else
    logic unused_fill;

    assign unused_fill = fill;
    assign fill_mode   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Transfer datapath. The parameters are latched only in IDLE, so a start
    // pulse during a transfer leaves them untouched. Both pointers advance at
    // the end of every WR and wrap naturally at AW bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sa       <= '0;
            da       <= '0;
            cnt      <= '0;
            data_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= src_addr;
                        da  <= dst_addr;
                        cnt <= len;
`ifdef DMA_FILL_EN
                        data_reg <= fill_word;
`endif
                    end
                end
                RD1: begin
                    data_reg <= in;
                end
                WR: begin
                    sa  <= sa + 1'b1;
                    da  <= da + 1'b1;
                    cnt <= cnt - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and bus outputs. bus_gnt is looked at only in REQ and on
    // leaving WR, so a word that has started always runs to its write. When
    // the grant is gone after a word, the FSM falls back to REQ and keeps
    // requesting.
    always_comb begin
        next_state = state;
        bus_req    = 1'b0;
        mem_cmd    = CMD_NONE;
        mem_addr   = '0;
        out        = '0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (len == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                if (bus_gnt) begin
                    next_state = fill_mode ? WR : RD0;
                end
            end
            RD0: begin
                bus_req    = 1'b1;
                busy       = 1'b1;
                mem_cmd    = CMD_READ;
                mem_addr   = sa;
                next_state = RD1;
            end
            RD1: begin
                bus_req    = 1'b1;
                busy       = 1'b1;
                mem_cmd    = CMD_READ;
                mem_addr   = sa;
                next_state = WR;
            end
            WR: begin
                bus_req  = 1'b1;
                busy     = 1'b1;
                mem_cmd  = CMD_WRITE;
                mem_addr = da;
                out      = data_reg;
                if (last_word) begin
                    next_state = DONE;
                end else if (bus_gnt) begin
                    next_state = fill_mode ? WR : RD0;
                end else begin
                    next_state = REQ;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
